// File: rtl/cpu16_mem_pkg.sv
// Shared types for the cpu16 memory bridge: FSM states, grant owner, bus word
// and the data word returned on an aborted access.
package cpu16_mem_pkg;

  typedef logic [15:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    INS,
    DAT
  } state_t;

  typedef enum logic {
    G_INS,
    G_DAT
  } grant_t;

  localparam word_t TIMEOUT_DATA = 16'hFFFF;

endpackage

// File: rtl/cpu16_mem_slot.sv
// Single-entry holding register for cpu16 data-port requests. Drops requests
// that arrive while it is occupied and flags them on a sticky overrun bit.
module cpu16_mem_slot
  import cpu16_mem_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  i_rd_req,
  input  logic  i_wr_req,
  input  word_t i_addr,
  input  word_t i_wdata,
  input  logic  i_free,
  output logic  o_cand,
  output logic  o_we,
  output word_t o_addr,
  output word_t o_wdata,
  output logic  o_err_overrun
);

  logic  r_valid;
  logic  r_we;
  word_t r_addr;
  word_t r_wdata;
  logic  r_err;
  logic  w_req;
  logic  w_accept;

  // The entry frees on its ack cycle, so a request in that same cycle fits.
  assign w_req    = i_rd_req | i_wr_req;
  assign w_accept = w_req & (~r_valid | i_free);

  // Candidate view for the arbiter: an entry loading now is visible at once.
  assign o_cand        = w_accept | (r_valid & ~i_free);
  assign o_we          = w_accept ? i_wr_req : r_we;
  assign o_addr        = w_accept ? i_addr   : r_addr;
  assign o_wdata       = w_accept ? i_wdata  : r_wdata;
  assign o_err_overrun = r_err;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_valid <= 1'b1;
        r_we    <= i_wr_req;
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
      end else if (i_free) begin
        r_valid <= 1'b0;
      end
      if ((w_req & ~w_accept) | (i_rd_req & i_wr_req)) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu16_mem_bridge.sv
// Arbitrates cpu16 fetch and data ports onto one req/ack memory port.
// Optional watchdog abort: define CPU16_MEM_BRIDGE_TIMEOUT_EN.
module cpu16_mem_bridge
  import cpu16_mem_pkg::*;
#(
  parameter bit DAT_FIRST = 1'b1
`ifdef CPU16_MEM_BRIDGE_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 255
`endif
) (
  input  logic  clk,
  input  logic  reset,
  input  word_t ins_rd_addr,
  input  logic  ins_rd_req,
  output word_t ins_rd_data,
  output logic  ins_rd_rdy,
  input  word_t dat_rw_addr,
  input  word_t dat_wr_data,
  input  logic  dat_rd_req,
  input  logic  dat_wr_req,
  output word_t dat_rd_data,
  output logic  dat_rd_rdy,
  output logic  dat_wr_rdy,
  output logic  mem_req,
  output logic  mem_we,
  output word_t mem_addr,
  output word_t mem_wdata,
  input  word_t mem_rdata,
  input  logic  mem_ack,
  output logic  err_overrun
`ifdef CPU16_MEM_BRIDGE_TIMEOUT_EN
  ,
  output logic  err_timeout
`endif
);

  state_t r_state;
  grant_t r_last_grant;
  logic   r_mem_req;
  logic   r_mem_we;
  word_t  r_mem_addr;
  word_t  r_mem_wdata;
  word_t  r_ins_iss_addr;
  word_t  r_ins_rd_data;
  word_t  r_dat_rd_data;
  logic   r_ins_rd_rdy;
  logic   r_dat_rd_rdy;
  logic   r_dat_wr_rdy;

  logic   w_busy;
  logic   w_done;
  logic   w_arb;
  logic   w_free;
  logic   w_grant_dat;
  logic   w_slot_cand;
  logic   w_slot_we;
  word_t  w_slot_addr;
  word_t  w_slot_wdata;
  word_t  w_rdata;

  cpu16_mem_slot u_slot (
    .clk           (clk),
    .reset         (reset),
    .i_rd_req      (dat_rd_req),
    .i_wr_req      (dat_wr_req),
    .i_addr        (dat_rw_addr),
    .i_wdata       (dat_wr_data),
    .i_free        (w_free),
    .o_cand        (w_slot_cand),
    .o_we          (w_slot_we),
    .o_addr        (w_slot_addr),
    .o_wdata       (w_slot_wdata),
    .o_err_overrun (err_overrun)
  );

  assign w_busy = (r_state != IDLE);
  assign w_arb  = (r_state == IDLE) | w_done;
  assign w_free = w_done & (r_state == DAT);
  // On a tie the port that did not win last time gets the memory.
  assign w_grant_dat = w_slot_cand & (~ins_rd_req | (r_last_grant == G_INS));

`ifdef CPU16_MEM_BRIDGE_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [7:0] r_wdog;
  logic       r_err_timeout;
  logic       w_tmo;

  assign w_tmo       = w_busy & ~mem_ack & (r_wdog == TMO_LAST);
  assign w_done      = w_busy & (mem_ack | w_tmo);
  assign w_rdata     = w_tmo ? TIMEOUT_DATA : mem_rdata;
  assign err_timeout = r_err_timeout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wdog        <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      if (w_arb) begin
        r_wdog <= '0;
      end else if (w_busy) begin
        r_wdog <= r_wdog + 8'd1;
      end
      if (w_tmo) begin
        r_err_timeout <= 1'b1;
      end
    end
  end
`else
  assign w_done  = w_busy & mem_ack;
  assign w_rdata = mem_rdata;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_last_grant   <= DAT_FIRST ? G_INS : G_DAT;
      r_mem_req      <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_ins_iss_addr <= '0;
      r_ins_rd_data  <= '0;
      r_dat_rd_data  <= '0;
      r_ins_rd_rdy   <= 1'b0;
      r_dat_rd_rdy   <= 1'b0;
      r_dat_wr_rdy   <= 1'b0;
    end else begin
      r_ins_rd_rdy <= 1'b0;
      r_dat_rd_rdy <= 1'b0;
      r_dat_wr_rdy <= 1'b0;

      if (w_done) begin
        if (r_state == DAT) begin
          if (r_mem_we) begin
            r_dat_wr_rdy <= 1'b1;
          end else begin
            r_dat_rd_rdy  <= 1'b1;
            r_dat_rd_data <= w_rdata;
          end
        end else if (ins_rd_req && (ins_rd_addr == r_ins_iss_addr)) begin
          // A fetch whose address moved on (branch) is silently dropped.
          r_ins_rd_rdy  <= 1'b1;
          r_ins_rd_data <= w_rdata;
        end
      end

      if (w_arb) begin
        if (w_grant_dat) begin
          r_state      <= DAT;
          r_last_grant <= G_DAT;
          r_mem_req    <= 1'b1;
          r_mem_we     <= w_slot_we;
          r_mem_addr   <= w_slot_addr;
          r_mem_wdata  <= w_slot_wdata;
        end else if (ins_rd_req) begin
          r_state        <= INS;
          r_last_grant   <= G_INS;
          r_mem_req      <= 1'b1;
          r_mem_we       <= 1'b0;
          r_mem_addr     <= ins_rd_addr;
          r_ins_iss_addr <= ins_rd_addr;
        end else begin
          r_state   <= IDLE;
          r_mem_req <= 1'b0;
          r_mem_we  <= 1'b0;
        end
      end
    end
  end

  assign ins_rd_data = r_ins_rd_data;
  assign ins_rd_rdy  = r_ins_rd_rdy;
  assign dat_rd_data = r_dat_rd_data;
  assign dat_rd_rdy  = r_dat_rd_rdy;
  assign dat_wr_rdy  = r_dat_wr_rdy;
  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;

endmodule

// File: tb/tb_cpu16_mem_bridge.sv
// Directed bench for cpu16_mem_bridge with a wait-state memory model that
// returns addr+16'h0100 on reads. Watchdog case needs CPU16_MEM_BRIDGE_TIMEOUT_EN.
module tb_cpu16_mem_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ins_rd_addr;
  logic        ins_rd_req;
  logic [15:0] ins_rd_data;
  logic        ins_rd_rdy;
  logic [15:0] dat_rw_addr;
  logic [15:0] dat_wr_data;
  logic        dat_rd_req;
  logic        dat_wr_req;
  logic [15:0] dat_rd_data;
  logic        dat_rd_rdy;
  logic        dat_wr_rdy;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        err_overrun;
`ifdef CPU16_MEM_BRIDGE_TIMEOUT_EN
  logic        err_timeout;
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  int          tb_wait = 0;
  logic        tb_ack_en = 1'b1;
  int          r_wcnt = 0;
  int          c_ins, c_rd, c_wr, c_req;
  logic [15:0] last_rd;
  int          idx, cyc, req_cyc;
  logic        stable, saw_200;
  logic [15:0] first_ins;

  cpu16_mem_bridge dut (
`ifdef CPU16_MEM_BRIDGE_TIMEOUT_EN
    .err_timeout (err_timeout),
`endif
    .clk         (clk),
    .reset       (reset),
    .ins_rd_addr (ins_rd_addr),
    .ins_rd_req  (ins_rd_req),
    .ins_rd_data (ins_rd_data),
    .ins_rd_rdy  (ins_rd_rdy),
    .dat_rw_addr (dat_rw_addr),
    .dat_wr_data (dat_wr_data),
    .dat_rd_req  (dat_rd_req),
    .dat_wr_req  (dat_wr_req),
    .dat_rd_data (dat_rd_data),
    .dat_rd_rdy  (dat_rd_rdy),
    .dat_wr_rdy  (dat_wr_rdy),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .err_overrun (err_overrun)
  );

  always #5 clk = ~clk;

  // Memory model: ack after tb_wait extra cycles of mem_req.
  assign mem_ack   = tb_ack_en && mem_req && (r_wcnt >= tb_wait);
  assign mem_rdata = mem_addr + 16'h0100;
  always @(posedge clk) r_wcnt <= (mem_req && !mem_ack) ? r_wcnt + 1 : 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clr();
    c_ins = 0; c_rd = 0; c_wr = 0; c_req = 0; last_rd = '0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      if (ins_rd_rdy) c_ins++;
      if (dat_rd_rdy) begin c_rd++; last_rd = dat_rd_data; end
      if (dat_wr_rdy) c_wr++;
      if (mem_req) c_req++;
    end
  endtask

  initial begin
    reset = 1'b1;
    ins_rd_addr = '0; ins_rd_req = 1'b0;
    dat_rw_addr = '0; dat_wr_data = '0; dat_rd_req = 1'b0; dat_wr_req = 1'b0;
    clr();
    repeat (2) step();

    // Reset state
    check("rst_mem_req", mem_req, 0);
    check("rst_rdys", {ins_rd_rdy, dat_rd_rdy, dat_wr_rdy}, 0);
    check("rst_err", err_overrun, 0);
    check("rst_datas", {ins_rd_data, dat_rd_data}, 0);
`ifdef CPU16_MEM_BRIDGE_TIMEOUT_EN
    check("rst_err_tmo", err_timeout, 0);
`endif
    reset = 1'b0;
    step();

    // 1: fetch stream, zero-wait memory
    tb_wait = 0;
    ins_rd_addr = 16'h0000; ins_rd_req = 1'b1;
    step();
    check("t1_grant_req", mem_req, 1);
    check("t1_grant_we", mem_we, 0);
    check("t1_rdy_not_yet", ins_rd_rdy, 0);
    step();
    check("t1_latency_rdy", ins_rd_rdy, 1);
    idx = 0; cyc = 0;
    while (idx < 3 && cyc < 40) begin
      if (ins_rd_rdy) begin
        check("t1_data", ins_rd_data, 16'h0100 + 16'(idx));
        idx++;
        if (idx < 3) ins_rd_addr = 16'(idx);
        else ins_rd_req = 1'b0;
      end
      if (idx < 3) step();
      cyc++;
    end
    check("t1_fetch_count", idx, 3);
    clr(); run(4);
    check("t1_no_extra_rdy", c_ins, 0);
    check("t1_idle", mem_req, 0);

    // 2: data read during a fetch stream
    tb_wait = 1;
    ins_rd_addr = 16'h0020; ins_rd_req = 1'b1;
    cyc = 0;
    while (!(mem_req && mem_addr == 16'h0020 && !mem_ack) && cyc < 10) begin step(); cyc++; end
    check("t2_ins_issued", {mem_req, mem_addr}, {1'b1, 16'h0020});
    dat_rw_addr = 16'h8000; dat_rd_req = 1'b1;
    step();
    dat_rd_req = 1'b0;
    step();
    check("t2_dat_granted", {mem_req, mem_we, mem_addr}, {2'b10, 16'h8000});
    cyc = 0;
    while (!dat_rd_rdy && cyc < 10) begin step(); cyc++; end
    check("t2_rd_rdy", dat_rd_rdy, 1);
    check("t2_rd_data", dat_rd_data, 16'h8100);
    check("t2_back_to_ins", {mem_req, mem_we, mem_addr}, {2'b10, 16'h0020});
    ins_rd_req = 1'b0;
    clr(); run(6);
    check("t2_idle", mem_req, 0);

    // 3: write with three wait states
    tb_wait = 3;
    dat_rw_addr = 16'h0040; dat_wr_data = 16'hBEEF; dat_wr_req = 1'b1;
    step();
    dat_wr_req = 1'b0;
    clr(); req_cyc = 0; stable = 1'b1; cyc = 0;
    while (mem_req && cyc < 20) begin
      if (mem_addr != 16'h0040 || mem_wdata != 16'hBEEF || !mem_we) stable = 1'b0;
      if (dat_wr_rdy) c_wr++;
      req_cyc++;
      step(); cyc++;
    end
    if (dat_wr_rdy) c_wr++;
    run(3);
    check("t3_req_cycles", req_cyc, 4);
    check("t3_stable", stable, 1);
    check("t3_wr_rdy_once", c_wr, 1);
    check("t3_no_rd_rdy", c_rd, 0);

    // Request on the slot's free cycle is accepted back to back
    tb_wait = 0;
    dat_rw_addr = 16'h0001; dat_rd_req = 1'b1;
    step();
    dat_rw_addr = 16'h0002;
    step();
    dat_rd_req = 1'b0;
    check("tf_first_rdy", {dat_rd_rdy, dat_rd_data}, {1'b1, 16'h0101});
    check("tf_second_issued", {mem_req, mem_addr}, {1'b1, 16'h0002});
    step();
    check("tf_second_rdy", {dat_rd_rdy, dat_rd_data}, {1'b1, 16'h0102});
    check("tf_no_overrun", err_overrun, 0);

    // 4: stale fetch after a branch
    tb_wait = 2;
    ins_rd_addr = 16'h0010; ins_rd_req = 1'b1;
    cyc = 0;
    while (!(mem_req && mem_addr == 16'h0010) && cyc < 10) begin step(); cyc++; end
    ins_rd_addr = 16'h0200;
    saw_200 = 1'b0; first_ins = '0; cyc = 0;
    while (!ins_rd_rdy && cyc < 20) begin
      step(); cyc++;
      if (mem_req && !mem_we && mem_addr == 16'h0200) saw_200 = 1'b1;
    end
    if (ins_rd_rdy) first_ins = ins_rd_data;
    check("t4_refetch_issued", saw_200, 1);
    check("t4_first_rdy_data", first_ins, 16'h0300);
    ins_rd_req = 1'b0;
    clr(); run(8);
    check("t4_idle", mem_req, 0);

    // 5a: overrun while the slot is full
    tb_wait = 3;
    dat_rw_addr = 16'h0123; dat_rd_req = 1'b1;
    step();
    dat_rw_addr = 16'h0456;
    step();
    dat_rd_req = 1'b0;
    check("t5_overrun", err_overrun, 1);
    clr(); run(10);
    check("t5_one_rd_rdy", c_rd, 1);
    check("t5_rd_data", last_rd, 16'h0223);
    check("t5_sticky", err_overrun, 1);

    // 5b: reset in the middle of a data access
    dat_rw_addr = 16'h0777; dat_rd_req = 1'b1;
    step();
    dat_rd_req = 1'b0;
    step();
    check("t5_mid_access", mem_req, 1);
    reset = 1'b1;
    #1;
    check("t5_rst_mem_req", mem_req, 0);
    check("t5_rst_mem_bus", {mem_we, mem_addr, mem_wdata}, 0);
    check("t5_rst_datas", {ins_rd_data, dat_rd_data}, 0);
    check("t5_rst_err", err_overrun, 0);
    step();
    reset = 1'b0;
    clr(); run(8);
    check("t5_no_rdy_after_rst", c_rd + c_wr + c_ins, 0);
    check("t5_slot_cleared", c_req, 0);

`ifdef CPU16_MEM_BRIDGE_TIMEOUT_EN
    // 6: watchdog abort with ack never arriving
    tb_ack_en = 1'b0;
    dat_rw_addr = 16'h0099; dat_rd_req = 1'b1;
    step();
    dat_rd_req = 1'b0;
    req_cyc = 0; cyc = 0;
    while (!dat_rd_rdy && cyc < 400) begin
      if (mem_req) req_cyc++;
      step(); cyc++;
    end
    check("t6_req_cycles", req_cyc, 255);
    check("t6_rdy_data", {dat_rd_rdy, dat_rd_data}, {1'b1, 16'hFFFF});
    check("t6_err_timeout", err_timeout, 1);
    check("t6_req_dropped", mem_req, 0);
    tb_ack_en = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
